// File: rtl/dmem_responder.sv
// Data-side MEM-stage responder: posted store buffer plus single-outstanding load port.
// Define WBUF_FWD_EN to forward full-word buffered stores to conflicting loads.
module dmem_responder #(
   parameter int WBUF_DEPTH = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MemRW,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [31:0]       dwdata,
   input  logic [3:0]        dbe,
   input  logic              iready_n,
   output logic [31:0]       drdata,
   output logic              dready_n,
   output logic              dbusy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   // state   | meaning
   // IDLE    | no backing transaction; pick a load, else drain the buffer head
   // RD_WAIT | load request outstanding, waiting for mem_ack
   // WR_WAIT | buffer-head write outstanding, waiting for mem_ack
   // RD_DONE | load data presented (dready_n=0) until the pipeline advances

   localparam int PTR_W = $clog2(WBUF_DEPTH);
   localparam int WA_W  = ADDR_W - 2;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(WBUF_DEPTH);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RD_DONE} state_t;
   state_t state;

   logic [WA_W-1:0]  buf_addr [WBUF_DEPTH];
   logic [31:0]      buf_data [WBUF_DEPTH];
   logic [3:0]       buf_be   [WBUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic             is_load;
   logic             is_store;
   logic             enq;
   logic             pop;
   logic             conflict;
   logic [PTR_W-1:0] scan_idx;
   logic             daddr_unused;

   assign is_load  = (MemRW == 2'b10);
   assign is_store = (MemRW == 2'b01);
   assign dbusy    = (count == CNT_MAX);
   assign enq      = is_store && !dbusy && !iready_n;
   assign pop      = (state == WR_WAIT) && mem_ack;
   assign daddr_unused = ^daddr[1:0];

   // Only the first `count` slots from the read pointer hold live stores.
   always_comb begin
      conflict = 1'b0;
      scan_idx = rd_ptr;
      for (int k = 0; k < WBUF_DEPTH; k++) begin
         scan_idx = rd_ptr + PTR_W'(k);
         if (((PTR_W+1)'(k) < count) && (buf_addr[scan_idx] == daddr[ADDR_W-1:2]))
            conflict = 1'b1;
      end
   end

`ifdef WBUF_FWD_EN
   logic             fwd_full;
   logic [31:0]      fwd_data;
   logic [PTR_W-1:0] fwd_idx;

   // Walk oldest to youngest so the youngest matching store decides.
   always_comb begin
      fwd_full = 1'b0;
      fwd_data = '0;
      fwd_idx  = rd_ptr;
      for (int k = 0; k < WBUF_DEPTH; k++) begin
         fwd_idx = rd_ptr + PTR_W'(k);
         if (((PTR_W+1)'(k) < count) && (buf_addr[fwd_idx] == daddr[ADDR_W-1:2])) begin
            fwd_full = (buf_be[fwd_idx] == 4'hF);
            fwd_data = buf_data[fwd_idx];
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({enq, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: validity lives entirely in the pointers.
   always_ff @(posedge clk) begin
      if (enq) begin
         buf_addr[wr_ptr] <= daddr[ADDR_W-1:2];
         buf_data[wr_ptr] <= dwdata;
         buf_be[wr_ptr]   <= dbe;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         drdata    <= '0;
         dready_n  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
`ifdef WBUF_FWD_EN
               if (is_load && conflict && fwd_full) begin
                  drdata   <= fwd_data;
                  dready_n <= 1'b0;
                  state    <= RD_DONE;
               end else
`endif
               if (is_load && !conflict) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {daddr[ADDR_W-1:2], 2'b00};
                  mem_be   <= 4'hF;
                  state    <= RD_WAIT;
               end else if (count != '0) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {buf_addr[rd_ptr], 2'b00};
                  mem_wdata <= buf_data[rd_ptr];
                  mem_be    <= buf_be[rd_ptr];
                  state     <= WR_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_ack) begin
                  drdata   <= mem_rdata;
                  mem_req  <= 1'b0;
                  dready_n <= 1'b0;
                  state    <= RD_DONE;
               end
            end
            WR_WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            RD_DONE: begin
               if (!iready_n) begin
                  dready_n <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word-level reference memory predicts load data
// and the program-order write stream; a backing-memory model checks the port protocol.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  MemRW;
   logic [31:0] daddr, dwdata;
   logic [3:0]  dbe;
   logic        iready_n;
   logic [31:0] drdata;
   logic        dready_n, dbusy;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   dmem_responder #(.WBUF_DEPTH(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .MemRW(MemRW), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
      .iready_n(iready_n), .drdata(drdata), .dready_n(dready_n), .dbusy(dbusy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   int total = 0;
   int bad   = 0;
   wr_t         wq[$];
   logic [31:0] rq[$];
   logic [31:0] bmem    [int unsigned];
   logic [31:0] ref_mem [int unsigned];

   int lat_sel = -1;
   bit hold    = 1'b0;
   int tokens  = 0;
   int rd_reqs = 0;
   int wr_acks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int unsigned w);
      return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] bmem_get(input int unsigned w);
      return bmem.exists(w) ? bmem[w] : init_word(w);
   endfunction

   function automatic logic [31:0] ref_get(input int unsigned w);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] bev);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (bev[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Backing memory: random or fixed latency, optional ack withholding (tokens release one each).
   initial begin : mem_model
      bit          in_txn, acked, pend;
      int          wait_c;
      logic        we_c;
      logic [31:0] a_c, d_c;
      logic [3:0]  be_c;
      wr_t         e;
      in_txn = 0; acked = 0; wait_c = 0;
      we_c = 0; a_c = 0; d_c = 0; be_c = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            in_txn = 0; acked = 0; mem_ack = 1'b0;
         end else if (acked) begin
            acked = 0;
            mem_ack = 1'b0;
            chk("req_gap_after_ack", 32'(mem_req), 32'd0);
         end else if (mem_req) begin
            if (!in_txn) begin
               in_txn = 1;
               we_c = mem_we; a_c = mem_addr; d_c = mem_wdata; be_c = mem_be;
               wait_c = (lat_sel < 0) ? int'($urandom_range(0, 3)) : lat_sel;
               chk("addr_align", 32'(a_c[1:0]), 32'd0);
               if (!we_c) begin
                  rd_reqs++;
                  chk("rd_be", 32'(be_c), 32'hF);
                  chk("rd_addr", a_c, {daddr[31:2], 2'b00});
                  pend = 0;
                  foreach (wq[i]) if (wq[i].addr[31:2] == a_c[31:2]) pend = 1;
                  chk("rd_before_drain", 32'(pend), 32'd0);
               end
            end else begin
               chk("req_addr_stable", mem_addr, a_c);
               chk("req_wdata_stable", mem_wdata, d_c);
               chk("req_we_be_stable", 32'({mem_we, mem_be}), 32'({we_c, be_c}));
            end
            if (wait_c > 0) begin
               wait_c--;
            end else if (!hold || tokens > 0) begin
               if (hold) tokens--;
               mem_ack = 1'b1;
               acked = 1;
               in_txn = 0;
               if (we_c) begin
                  wr_acks++;
                  if (wq.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_write actual_addr=%h required=none", a_c);
                  end else begin
                     e = wq.pop_front();
                     chk("wr_addr", a_c, e.addr);
                     chk("wr_data", d_c, e.data);
                     chk("wr_be", 32'(be_c), 32'(e.be));
                  end
                  bmem[a_c >> 2] = merge(bmem_get(a_c >> 2), d_c, be_c);
               end else begin
                  mem_rdata = bmem_get(a_c >> 2);
               end
            end
         end
      end
   end

   initial begin : load_mon
      bit          prev;
      logic [31:0] held;
      prev = 0; held = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            prev = 0;
         end else if (!dready_n) begin
            if (!prev) begin
               if (rq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_load_data actual=%h required=none", drdata);
               end else begin
                  chk("load_data", drdata, rq.pop_front());
               end
               held = drdata;
               prev = 1;
            end else begin
               chk("load_data_hold", drdata, held);
            end
         end else begin
            prev = 0;
         end
      end
   end

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bev,
                           input int stall);
      int t;
      MemRW = 2'b01; daddr = a; dwdata = d; dbe = bev; iready_n = 1'b1;
      repeat (stall) @(negedge clk);
      iready_n = 1'b0;
      t = 0;
      while (dbusy && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (dbusy) begin
         total++; bad++;
         $display("FAIL store_accept_timeout dbusy=%b required=0", dbusy);
         MemRW = 2'b00;
      end else begin
         wq.push_back('{addr: {a[31:2], 2'b00}, data: d, be: bev});
         ref_mem[a >> 2] = merge(ref_get(a >> 2), d, bev);
      end
      @(negedge clk);
   endtask

   task automatic do_load(input logic [31:0] a, input int stall, input int exp_lat);
      int n;
      MemRW = 2'b10; daddr = a; iready_n = 1'b1;
      rq.push_back(ref_get(a >> 2));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dready_n && n < 400);
      if (dready_n) begin
         total++; bad++;
         $display("FAIL load_timeout dready_n=%b required=0", dready_n);
         rq.delete();
         MemRW = 2'b00; iready_n = 1'b0;
         return;
      end
      if (exp_lat >= 0) chk("load_latency", n, exp_lat);
      repeat (stall) begin
         @(negedge clk);
         chk("rd_done_hold", 32'(dready_n), 32'd0);
      end
      iready_n = 1'b0;
      @(negedge clk);
      chk("dready_release", 32'(dready_n), 32'd1);
   endtask

   task automatic do_idle();
      MemRW = 2'b00;
      iready_n = 1'($urandom_range(0, 1));
      @(negedge clk);
   endtask

   task automatic wait_drain();
      int t;
      MemRW = 2'b00; iready_n = 1'b0;
      t = 0;
      while ((wq.size() > 0 || mem_req) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", wq.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin : driver
      int w0, r0, t;
      logic [31:0] a;
      MemRW = 2'b00; daddr = 0; dwdata = 0; dbe = 0; iready_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_dready_n", 32'(dready_n), 32'd1);
      chk("rst_dbusy", 32'(dbusy), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_drdata", drdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // plain load, fixed latency, one-cycle data window
      bmem[32'h104 >> 2] = 32'hDEAD_BEEF;
      ref_mem[32'h104 >> 2] = 32'hDEAD_BEEF;
      lat_sel = 3;
      do_load(32'h104, 0, -1);
      // minimum latency, then a held RD_DONE
      lat_sel = 0;
      do_load(32'h108, 0, 2);
      do_load(32'h10C, 2, 2);

      // fill the buffer with acks withheld, release one to admit the fifth store
      hold = 1'b1; tokens = 0;
      for (int i = 0; i < 3; i++) do_store(32'h400 + 32'(4 * i), $urandom, 4'hF, 0);
      chk("dbusy_at_3", 32'(dbusy), 32'd0);
      do_store(32'h40C, $urandom, 4'hF, 0);
      chk("dbusy_at_4", 32'(dbusy), 32'd1);
      fork
         do_store(32'h410, $urandom, 4'hF, 0);
         begin
            repeat (3) @(negedge clk);
            chk("dbusy_held", 32'(dbusy), 32'd1);
            tokens = 1;
         end
      join
      hold = 1'b0; lat_sel = -1;
      wait_drain();

      // store held by a stall is written exactly once
      w0 = wr_acks;
      do_store(32'h500, 32'h1234_5678, 4'hF, 3);
      wait_drain();
      chk("stall_store_writes", wr_acks - w0, 1);

      // RAW on one word
      r0 = rd_reqs;
      do_store(32'h200, 32'h0000_00AA, 4'hF, 0);
`ifdef WBUF_FWD_EN
      do_load(32'h200, 0, 1);
      chk("fwd_no_read", rd_reqs - r0, 0);
`else
      do_load(32'h200, 0, -1);
      chk("raw_one_read", rd_reqs - r0, 1);
`endif
      wait_drain();

      // reset while a read is outstanding and two stores are buffered
      hold = 1'b1; tokens = 0; lat_sel = 0;
      do_store(32'h600, $urandom, 4'hF, 0);
      do_store(32'h604, $urandom, 4'hF, 0);
      do_store(32'h608, $urandom, 4'hF, 0);
      MemRW = 2'b10; daddr = 32'h700; iready_n = 1'b1;
      tokens = 1;
      t = 0;
      while (!(mem_req && !mem_we) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("rd_wait_reached", 32'(mem_req && !mem_we), 32'd1);
      chk("two_buffered", 32'(wq.size()), 32'd2);
      rst = 1'b0;
      #1;
      chk("midrst_mem_req", 32'(mem_req), 32'd0);
      chk("midrst_dready_n", 32'(dready_n), 32'd1);
      chk("midrst_dbusy", 32'(dbusy), 32'd0);
      wq.delete();
      rq.delete();
      ref_mem = bmem;
      MemRW = 2'b00; hold = 1'b0; tokens = 0; lat_sel = -1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      w0 = wr_acks; r0 = rd_reqs;
      repeat (10) @(negedge clk);
      chk("post_rst_writes", wr_acks - w0, 0);
      chk("post_rst_reads", rd_reqs - r0, 0);

      // randomized mix over a small word window to provoke conflicts
      for (int i = 0; i < 300; i++) begin
         a = 32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0, 1, 2, 3:
               do_store(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 15)),
                        int'($urandom_range(0, 2)));
            4, 5, 6, 7:
               do_load(a, int'($urandom_range(0, 2)), -1);
            default:
               do_idle();
         endcase
      end
      wait_drain();
      chk("loads_all_returned", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder for the 5-stage pipeline's MEM stage. It generates `dready_n` and `dbusy`, which the hazard/stall unit uses as `(dready_n && MemRW[1])` and `(dbusy && MemRW[0])`.
- Stores are accepted into a posted write buffer. Loads are served through a single-outstanding backing-memory port with req/ack handshake.
- It sits between the MEM stage and the data memory/cache.

Parameters:
- WBUF_DEPTH, 4, write-buffer entries; power of 2, ≥2.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- MemRW  input  2  MEM-stage access: 2'b10 load, 2'b01 store, 2'b00 none, 2'b11 reserved (treated as 2'b00)
- daddr  input  ADDR_W  byte address of the access
- dwdata  input  32  store data
- dbe  input  4  store byte enables
- iready_n  input  1  instruction-side not-ready; high means the MEM stage will not advance this cycle
- drdata  output  32  load data, valid while dready_n=0
- dready_n  output  1  low = load data valid this cycle
- dbusy  output  1  high = write buffer full, store not accepted
- mem_req  output  1  backing request, held until ack
- mem_we  output  1  1 = write transaction, 0 = read
- mem_addr  output  ADDR_W  word-aligned address ([1:0]=0)
- mem_wdata  output  32  write data
- mem_be  output  4  write byte enables (4'b1111 on reads)
- mem_ack  input  1  one-cycle completion pulse
- mem_rdata  input  32  read data, valid with mem_ack

Behaviour:
- Reset (async, rst=0):
  - FSM to IDLE; buffer emptied (pointers=0, count=0).
  - Outputs: dready_n=1, dbusy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, drdata=0.
  - An in-flight backing transaction is abandoned, and buffered stores are discarded.
- Write buffer:
  - FIFO of {word addr, data, be}.
  - dbusy = (count==WBUF_DEPTH), taken from registered state only, with no combinational path from MemRW.
  - Enqueue on an edge when MemRW==01 && !dbusy && !iready_n, so a stalled store is enqueued exactly once.
  - Enqueue and pop on the same edge is legal; count is unchanged.
  - When full, dbusy stays high until the first pop edge. The held store enqueues on the next edge after dbusy falls.
- Load conflict:
  - conflict = any valid buffer entry with addr[ADDR_W-1:2] equal to daddr[ADDR_W-1:2].
  - A conflicting load never bypasses; the buffer drains until conflict is false.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RD_DONE.
- IDLE:
  - If MemRW==10 && !conflict: mem_req=1, mem_we=0, mem_addr={daddr[ADDR_W-1:2],2'b00}; go to RD_WAIT.
  - Else if count>0: present the head entry, mem_req=1, mem_we=1; go to WR_WAIT.
  - Loads have priority over draining.
- RD_WAIT: on mem_ack, drdata<=mem_rdata, mem_req<=0, dready_n<=0; go to RD_DONE.
- WR_WAIT:
  - Request fields stay stable until ack.
  - On mem_ack: pop the head, mem_req<=0; go to IDLE.
- RD_DONE:
  - dready_n and drdata are held.
  - If iready_n==0: dready_n<=1 and go to IDLE; the pipeline advances on this edge.
  - Otherwise remain in RD_DONE.
- Backing-port latency:
  - Minimum load latency is request cycle, then ack cycle, then the RD_DONE cycle, so dready_n is low 2 cycles after the load appears with ack at 1.
  - mem_req is never high in the cycle after an ack (one idle cycle between transactions).
- Outside RD_DONE, dready_n=1 whatever MemRW is; the stall unit masks it with MemRW[1].

Optional Feature:
- WBUF_FWD_EN: store-to-load forwarding.
- Defined: in IDLE, if a load conflicts and the youngest matching entry has be==4'b1111:
  - drdata<=that entry's data, dready_n<=0.
  - Go directly to RD_DONE with no backing access; the buffer is not drained.
  - A partial-be match still drains.
- Undefined: every conflicting load drains the buffer first.

Test Plan:
- Load, no conflict: MemRW=10, daddr=0x104, backing acks 3 cycles after mem_req with 0xDEADBEEF → mem_addr=0x104, mem_we=0, dready_n=0 for exactly one cycle, drdata=0xDEADBEEF.
- Buffer full: 5 consecutive stores with iready_n=0 and backing ack withheld → dbusy=1 after the 4th; the 5th is enqueued on the edge after the first ack; backing writes occur in program order.
- Stall-hold store: MemRW=01 held 3 cycles with iready_n=1, then 0 → exactly one buffer entry and one backing write.
- RAW conflict: store 0x0000_00AA to 0x200 (be=1111) then load 0x200 → backing write to 0x200 completes before the read is issued; drdata is the read return. With WBUF_FWD_EN: no mem_req for the load, drdata=0x000000AA, dready_n low 1 cycle after the load appears.
- RD_DONE hold: iready_n=1 for 2 cycles after read ack → dready_n stays 0 and drdata is stable until iready_n=0.
- Reset mid-op: rst=0 during RD_WAIT with 2 buffered stores → mem_req=0, dready_n=1, dbusy=0 immediately; no writes issued after rst=1.
